// File: rtl/eth_pcs_tx_sequencer_if.sv
// Encoder-side block handshake and scrambler/gearbox-side word bus of the TX PCS sequencer.
// master = the sequencer itself, slave = the surrounding datapath.
interface eth_pcs_tx_sequencer_if;
  logic        i_en;
  logic        i_test_mode;
  logic        i_blk_valid;
  logic        o_blk_ready;
  logic [1:0]  i_blk_header;
  logic [63:0] i_blk_data;
  logic        o_scr_valid;
  logic        i_scr_ready;
  logic [31:0] o_scr_data;
  logic        o_scr_bypass;
  logic [1:0]  o_tx_header;
  logic [5:0]  o_tx_sequence;
  logic        o_idle_insert;
  logic        o_hdr_err;

  modport master (
    input  i_en, i_test_mode, i_blk_valid, i_blk_header, i_blk_data, i_scr_ready,
    output o_blk_ready, o_scr_valid, o_scr_data, o_scr_bypass,
           o_tx_header, o_tx_sequence, o_idle_insert, o_hdr_err
  );

  modport slave (
    output i_en, i_test_mode, i_blk_valid, i_blk_header, i_blk_data, i_scr_ready,
    input  o_blk_ready, o_scr_valid, o_scr_data, o_scr_bypass,
           o_tx_header, o_tx_sequence, o_idle_insert, o_hdr_err
  );
endinterface

// File: rtl/eth_pcs_tx_sequencer.sv
// 10GBASE-R TX sequencer: splits 66b blocks into two 32b scrambler words, runs the gearbox
// sequence counter with a pause slot, inserts idles, and delays header/sequence to the scrambler output.
module eth_pcs_tx_sequencer #(
  parameter int unsigned SEQ_WRAP   = 32,
  parameter logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  eth_pcs_tx_sequencer_if.master bus
);
  localparam logic [5:0] SEQ_LAST = 6'(SEQ_WRAP);
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {SLOT_LOAD, SLOT_SECOND, SLOT_PAUSE} slot_e;

  logic [5:0]  seq_q, seq_d;
  logic        phase_q, phase_d;
  logic [31:0] hi_q, hi_d;
  logic        scr_valid_q, scr_valid_d;
  logic [31:0] scr_data_q, scr_data_d;
  logic        bypass_q, bypass_d;
  logic [1:0]  hdr1_q, hdr1_d;
  logic [5:0]  seq1_q, seq1_d;
  logic        pipe_vld_q, pipe_vld_d;
  logic [1:0]  tx_hdr_q, tx_hdr_d;
  logic [5:0]  tx_seq_q, tx_seq_d;
  logic        idle_q, idle_d;
  logic        hdr_err_q, hdr_err_d;
  logic        adv;
  slot_e       slot;

  always_comb begin
    adv = bus.i_en & bus.i_scr_ready;
    if (seq_q == SEQ_LAST) begin
      slot = SLOT_PAUSE;
    end else if (phase_q) begin
      slot = SLOT_SECOND;
    end else begin
      slot = SLOT_LOAD;
    end
  end

  always_comb begin
    seq_d       = seq_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    scr_valid_d = scr_valid_q;
    scr_data_d  = scr_data_q;
    bypass_d    = bypass_q;
    hdr1_d      = hdr1_q;
    seq1_d      = seq1_q;
    pipe_vld_d  = pipe_vld_q;
    tx_hdr_d    = tx_hdr_q;
    tx_seq_d    = tx_seq_q;
    idle_d      = 1'b0;
    hdr_err_d   = 1'b0;

    if (!bus.i_en) begin
      seq_d       = '0;
      phase_d     = 1'b0;
      scr_valid_d = 1'b0;
      pipe_vld_d  = 1'b0;
    end else if (bus.i_scr_ready) begin
      seq_d      = (slot == SLOT_PAUSE) ? 6'd0 : seq_q + 6'd1;
      phase_d    = (slot == SLOT_PAUSE) ? phase_q : ~phase_q;
      seq1_d     = seq_q;
      pipe_vld_d = 1'b1;
      // Stage 1 only becomes meaningful after one advance following a restart.
      if (pipe_vld_q) begin
        tx_hdr_d = hdr1_q;
        tx_seq_d = seq1_q;
      end
      case (slot)
        SLOT_LOAD: begin
          scr_valid_d = 1'b1;
          bypass_d    = bus.i_test_mode;
          if (bus.i_blk_valid) begin
            scr_data_d = bus.i_blk_data[31:0];
            hi_d       = bus.i_blk_data[63:32];
            hdr1_d     = bus.i_blk_header;
            hdr_err_d  = (bus.i_blk_header == 2'b00) || (bus.i_blk_header == 2'b11);
          end else begin
            scr_data_d = IDLE_BLOCK[31:0];
            hi_d       = IDLE_BLOCK[63:32];
            hdr1_d     = HDR_CTRL;
            idle_d     = 1'b1;
          end
        end
        SLOT_SECOND: begin
          scr_valid_d = 1'b1;
          scr_data_d  = hi_q;
        end
        default: begin
          scr_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      scr_valid_q <= 1'b0;
      scr_data_q  <= '0;
      bypass_q    <= 1'b0;
      hdr1_q      <= '0;
      seq1_q      <= '0;
      pipe_vld_q  <= 1'b0;
      tx_hdr_q    <= HDR_CTRL;
      tx_seq_q    <= '0;
      idle_q      <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      scr_valid_q <= scr_valid_d;
      scr_data_q  <= scr_data_d;
      bypass_q    <= bypass_d;
      hdr1_q      <= hdr1_d;
      seq1_q      <= seq1_d;
      pipe_vld_q  <= pipe_vld_d;
      tx_hdr_q    <= tx_hdr_d;
      tx_seq_q    <= tx_seq_d;
      idle_q      <= idle_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign bus.o_blk_ready   = adv & (slot == SLOT_LOAD);
  assign bus.o_scr_valid   = scr_valid_q;
  assign bus.o_scr_data    = scr_data_q;
  assign bus.o_scr_bypass  = bypass_q;
  assign bus.o_tx_header   = tx_hdr_q;
  assign bus.o_tx_sequence = tx_seq_q;
  assign bus.o_idle_insert = idle_q;
  assign bus.o_hdr_err     = hdr_err_q;
endmodule

// File: tb/tb_eth_pcs_tx_sequencer.sv
// Directed bench for eth_pcs_tx_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_eth_pcs_tx_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  eth_pcs_tx_sequencer_if bus ();

  eth_pcs_tx_sequencer #(
    .SEQ_WRAP  (32),
    .IDLE_BLOCK(64'h0000_0000_0000_001E)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  bus.o_scr_valid,   1'b0);
    chk({tag, "_data"},   bus.o_scr_data,    32'h0);
    chk({tag, "_bypass"}, bus.o_scr_bypass,  1'b0);
    chk({tag, "_hdr"},    bus.o_tx_header,   2'b10);
    chk({tag, "_seq"},    bus.o_tx_sequence, 6'd0);
    chk({tag, "_idle"},   bus.o_idle_insert, 1'b0);
    chk({tag, "_hdrerr"}, bus.o_hdr_err,     1'b0);
  endtask

  function automatic logic [63:0] mk(input int b);
    mk = {32'hB000_0000 | 32'(b), 32'hA000_0000 | 32'(b)};
  endfunction

  int          blk;
  int          nrdy;
  int          nidle;
  int          s;
  bit          ld;
  logic [63:0] d;

  initial begin
    rst_n            = 1'b0;
    bus.i_en         = 1'b1;
    bus.i_scr_ready  = 1'b1;
    bus.i_test_mode  = 1'b0;
    bus.i_blk_valid  = 1'b0;
    bus.i_blk_header = 2'b01;
    bus.i_blk_data   = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst_n = 1'b1;

    // Back-to-back valid blocks through one full sequence period and into the next.
    blk  = 0;
    nrdy = 0;
    for (int c = 0; c < 35; c++) begin
      s  = c % 33;
      ld = (s < 32) && (s % 2 == 0);
      d  = mk(blk);
      bus.i_blk_valid  = 1'b1;
      bus.i_blk_header = 2'b01;
      bus.i_blk_data   = d;
      #1;
      chk("stream_ready", bus.o_blk_ready, ld);
      if (c < 33 && bus.o_blk_ready) nrdy++;
      tick();
      chk("stream_valid", bus.o_scr_valid, s != 32);
      if (ld) begin
        chk("stream_word0", bus.o_scr_data, d[31:0]);
        blk++;
      end else begin
        d = mk(blk - 1);
        chk("stream_word1", bus.o_scr_data, d[63:32]);
      end
      chk("stream_txseq", bus.o_tx_sequence, (c == 0) ? 0 : (c - 1) % 33);
    end
    chk("stream_blocks_per_33", nrdy, 16);
    chk("stream_txhdr", bus.o_tx_header, 2'b01);

    // Underflow: three idle blocks (seq 2..7).
    nidle = 0;
    bus.i_blk_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("idle_ready", bus.o_blk_ready, k % 2 == 0);
      tick();
      if (bus.o_idle_insert) nidle++;
      if (k % 2 == 0) begin
        chk("idle_word0", bus.o_scr_data, 32'h0000_001E);
      end else begin
        chk("idle_word1", bus.o_scr_data, 32'h0000_0000);
        chk("idle_txhdr", bus.o_tx_header, 2'b10);
      end
    end
    chk("idle_pulses", nidle, 3);

    // Illegal sync header forwarded unchanged (seq 8).
    bus.i_blk_valid  = 1'b1;
    bus.i_blk_header = 2'b11;
    bus.i_blk_data   = 64'hDEADBEEF_01234567;
    tick();
    chk("hdr11_word0", bus.o_scr_data, 32'h0123_4567);
    chk("hdr11_err_pulse", bus.o_hdr_err, 1'b1);
    bus.i_blk_header = 2'b01;
    bus.i_blk_data   = 64'h0;
    tick();
    chk("hdr11_word1", bus.o_scr_data, 32'hDEAD_BEEF);
    chk("hdr11_err_clear", bus.o_hdr_err, 1'b0);
    chk("hdr11_txhdr", bus.o_tx_header, 2'b11);

    // Scrambler stall between word0 and word1 (seq 10).
    bus.i_blk_data = 64'h1111_2222_3333_4444;
    #1;
    chk("stall_ready_load", bus.o_blk_ready, 1'b1);
    tick();
    chk("stall_word0", bus.o_scr_data, 32'h3333_4444);
    bus.i_scr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready_low", bus.o_blk_ready, 1'b0);
      tick();
      chk("stall_hold_data", bus.o_scr_data, 32'h3333_4444);
      chk("stall_hold_txseq", bus.o_tx_sequence, 6'd9);
    end
    bus.i_scr_ready = 1'b1;
    #1;
    chk("stall_ready_second", bus.o_blk_ready, 1'b0);
    tick();
    chk("stall_word1", bus.o_scr_data, 32'h1111_2222);
    chk("stall_txseq_resume", bus.o_tx_sequence, 6'd10);
    nrdy = 0;
    for (int k = 0; k < 33; k++) begin
      #1;
      if (bus.o_blk_ready) nrdy++;
      tick();
    end
    chk("stall_blocks_per_33", nrdy, 16);

    // Test mode raised mid-block (LOAD at seq 12, 14, 16).
    bus.i_test_mode = 1'b0;
    tick();
    chk("tm_load0", bus.o_scr_bypass, 1'b0);
    bus.i_test_mode = 1'b1;
    tick();
    chk("tm_second0", bus.o_scr_bypass, 1'b0);
    tick();
    chk("tm_load1", bus.o_scr_bypass, 1'b1);
    bus.i_test_mode = 1'b0;
    tick();
    chk("tm_second1", bus.o_scr_bypass, 1'b1);
    tick();
    chk("tm_load2", bus.o_scr_bypass, 1'b0);

    // Enable dropped at seq 17 for two cycles.
    bus.i_en = 1'b0;
    #1;
    chk("en_ready_low", bus.o_blk_ready, 1'b0);
    tick();
    chk("en_valid_low0", bus.o_scr_valid, 1'b0);
    tick();
    chk("en_valid_low1", bus.o_scr_valid, 1'b0);
    bus.i_en       = 1'b1;
    bus.i_blk_data = 64'h5555_6666_7777_8888;
    #1;
    chk("en_restart_ready", bus.o_blk_ready, 1'b1);
    tick();
    chk("en_restart_valid", bus.o_scr_valid, 1'b1);
    chk("en_restart_word0", bus.o_scr_data, 32'h7777_8888);
    tick();
    chk("en_restart_word1", bus.o_scr_data, 32'h5555_6666);
    chk("en_restart_txseq", bus.o_tx_sequence, 6'd0);

    // Async reset mid-block at seq 9.
    bus.i_blk_data = 64'h9999_AAAA_BBBB_CCCC;
    repeat (7) tick();
    chk("prerst_word0", bus.o_scr_data, 32'hBBBB_CCCC);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst1");
    tick();
    chk_reset_vals("rst1_hold");
    rst_n = 1'b1;
    #1;
    chk("rst1_restart_ready", bus.o_blk_ready, 1'b1);
    tick();
    chk("rst1_restart_valid", bus.o_scr_valid, 1'b1);
    chk("rst1_restart_word0", bus.o_scr_data, 32'hBBBB_CCCC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
